// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-high segment decoder.
module hex_to_7seg
  import seg_pkg::*;
(
  input  nibble_t    nibble_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: scan_clk is synchronized and edge-detected
// into a one-cycle tick that advances the digit index; all outputs registered.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segments,
  output logic                    dp
);

  localparam int unsigned           IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_INACT  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_INACT = {7{ACTIVE_LOW}};

  logic                  s1_q, s2_q, s3_q;
  logic                  tick_c;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [6:0]            segments_q, segments_d;
  logic                  dp_q, dp_d;

  nibble_t               nib_c;
  logic                  en_c;
  logic                  dp_req_c;
  logic [6:0]            seg_raw_c;

  assign tick_c = s2_q & ~s3_q;

  // Explicit wrap so non-power-of-2 digit counts never reach unused indices.
  always_comb begin
    idx_d = idx_q;
    if (tick_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    nib_c    = '0;
    en_c     = 1'b0;
    dp_req_c = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_c    = value[4*i +: 4];
        en_c     = digit_en[i];
        dp_req_c = dp_in[i];
      end
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nib_c),
    .seg_c_o  (seg_raw_c)
  );

  // Build active-high outputs, then apply board polarity in one place.
  always_comb begin
    anodes_d   = '0;
    segments_d = SEG_OFF;
    dp_d       = 1'b0;
    if (en_c) begin
      anodes_d   = NUM_DIGITS'(1) << idx_q;
      segments_d = seg_raw_c;
      dp_d       = dp_req_c;
    end
    anodes_d   = anodes_d ^ AN_INACT;
    segments_d = segments_d ^ SEG_INACT;
    dp_d       = dp_d ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      idx_q      <= '0;
      anodes_q   <= AN_INACT;
      segments_q <= SEG_INACT;
      dp_q       <= ACTIVE_LOW;
    end else begin
      s1_q       <= scan_clk;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      idx_q      <= idx_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
      dp_q       <= dp_d;
    end
  end

  assign anodes   = anodes_q;
  assign segments = segments_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (8-digit and 6-digit instances, active-low).
module tb_seven_seg_scanner;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        scan8, scan6;
  logic [31:0] value8;
  logic [23:0] value6;
  logic [7:0]  en8, dp8;
  logic [5:0]  en6, dp6;
  logic [7:0]  an8;
  logic [5:0]  an6;
  logic [6:0]  seg8, seg6;
  logic        dpo8, dpo6;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int idx8 = 0;
  int idx6 = 0;

  int         q_edge[$];
  int         q_dut[$];
  logic [15:0] q_exp[$];
  string      q_tag[$];

  seven_seg_scanner #(.NUM_DIGITS(8), .ACTIVE_LOW(1'b1)) dut8 (
    .clk_in(clk_in), .reset(reset), .scan_clk(scan8), .value(value8),
    .digit_en(en8), .dp_in(dp8), .anodes(an8), .segments(seg8), .dp(dpo8)
  );

  seven_seg_scanner #(.NUM_DIGITS(6), .ACTIVE_LOW(1'b1)) dut6 (
    .clk_in(clk_in), .reset(reset), .scan_clk(scan6), .value(value6),
    .digit_en(en6), .dp_in(dp6), .anodes(an6), .segments(seg6), .dp(dpo6)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [6:0] hex_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected {anodes, segments, dp} in board (low-true) polarity, anodes padded to 8.
  function automatic logic [15:0] model(input int idx, input logic [31:0] val,
                                        input logic [7:0] en, input logic [7:0] dpv);
    logic [7:0] an;
    logic [6:0] seg;
    logic       d;
    an  = '0;
    seg = '0;
    d   = 1'b0;
    if (en[idx]) begin
      an[idx] = 1'b1;
      seg     = hex_ref(val[4*idx +: 4]);
      d       = dpv[idx];
    end
    return ~{an, seg, d};
  endfunction

  function automatic logic [15:0] exp_of(input int dut, input int idx);
    if (dut == 0) return model(idx, value8, en8, dp8);
    return model(idx, {8'h00, value6}, {2'b00, en6}, {2'b00, dp6});
  endfunction

  task automatic push(input int e, input int dut, input string tag, input logic [15:0] exp);
    q_edge.push_back(e);
    q_dut.push_back(dut);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One scan_clk rising edge: old digit held through edge c+3, new digit at c+4.
  task automatic pulse(input int dut, input string tag);
    int c;
    c = cyc;
    if (dut == 0) begin
      push(c + 3, 0, {tag, "_hold"}, exp_of(0, idx8));
      idx8 = (idx8 + 1) % 8;
      push(c + 4, 0, tag, exp_of(0, idx8));
      scan8 = 1'b1;
    end else begin
      push(c + 3, 1, {tag, "_hold"}, exp_of(1, idx6));
      idx6 = (idx6 + 1) % 6;
      push(c + 4, 1, tag, exp_of(1, idx6));
      scan6 = 1'b1;
    end
    step(2);
    scan8 = 1'b0;
    scan6 = 1'b0;
    step(2);
  endtask

  // Pop and compare every expectation due at the edge just taken.
  always @(negedge clk_in) begin
    logic [15:0] got;
    while (q_edge.size() > 0 && q_edge[0] <= cyc) begin
      if (q_edge[0] < cyc) begin
        check({q_tag[0], "_missed"}, 32'(cyc), 32'(q_edge[0]));
      end else begin
        got = (q_dut[0] == 0) ? {an8, seg8, dpo8} : {2'b11, an6, seg6, dpo6};
        check(q_tag[0], {16'h0, got}, {16'h0, q_exp[0]});
      end
      void'(q_edge.pop_front());
      void'(q_dut.pop_front());
      void'(q_exp.pop_front());
      void'(q_tag.pop_front());
    end
  end

  initial begin
    reset  = 1'b1;
    scan8  = 1'b0;
    scan6  = 1'b0;
    value8 = 32'h0000_0005;
    en8    = 8'hFF;
    dp8    = 8'h00;
    value6 = 24'h54_3210;
    en6    = 6'h3F;
    dp6    = 6'h00;

    step(2);
    push(cyc + 1, 0, "reset8", 16'hFFFF);
    push(cyc + 1, 1, "reset6", 16'hFFFF);
    step(1);
    reset = 1'b0;
    push(cyc + 1, 0, "first_d0", {8'hFE, 7'h12, 1'b1});
    step(1);

    value8 = 32'h89AB_CDEF;
    push(cyc + 1, 0, "val_chg", exp_of(0, 0));
    step(1);
    for (int i = 0; i < 8; i++) pulse(0, $sformatf("scan%0d", i));

    en8 = 8'b0000_0101;
    push(cyc + 1, 0, "blank_en", exp_of(0, 0));
    step(1);
    for (int i = 0; i < 4; i++) pulse(0, $sformatf("blank%0d", i));

    en8 = 8'hFF;
    push(cyc + 1, 0, "pre_rst_d4", exp_of(0, 4));
    step(1);
    reset = 1'b1;
    scan8 = 1'b1;
    push(cyc + 1, 0, "rst_mid", 16'hFFFF);
    step(2);
    reset = 1'b0;
    idx8  = 0;
    idx6  = 0;
    push(cyc + 1, 0, "rst_d0", exp_of(0, 0));
    push(cyc + 3, 0, "rst_hold", exp_of(0, 0));
    push(cyc + 4, 0, "rst_tick", exp_of(0, 1));
    push(cyc + 8, 0, "rst_once", exp_of(0, 1));
    idx8 = 1;
    step(8);
    scan8 = 1'b0;
    step(3);

    value8 = 32'h0123_4567;
    dp8    = 8'h01;
    scan8  = 1'b1;
    push(cyc + 1, 0, "glitch_val", exp_of(0, 1));
    push(cyc + 3, 0, "glitch_hold", exp_of(0, 1));
    push(cyc + 4, 0, "glitch_tick", exp_of(0, 2));
    push(cyc + 8, 0, "glitch_once", exp_of(0, 2));
    idx8 = 2;
    step(1);
    scan8 = 1'b0;
    step(7);
    for (int i = 0; i < 6; i++) pulse(0, $sformatf("dp%0d", i));

    push(cyc + 1, 1, "w6_start", exp_of(1, 0));
    step(1);
    for (int i = 0; i < 7; i++) pulse(1, $sformatf("w6_%0d", i));

    step(6);
    check("drain", 32'(q_edge.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
